muldiv_requester: RTL and testbench

MULDIV_REQUESTER -- requirements
Module: muldiv_requester

---
 rtl/muldiv_requester.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_requester.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_requester.sv
// muldiv_requester
//   Sequences one multiply/divide operation at a time onto a shared
//   multiply/divide core.
//   - Accepts a command from the host (valid/ready handshake).
//   - Registers the operands for the core.
//   - Pulses go for GO_CYCLES cycles.
//   - Waits for a fresh rising edge on the core's done level.
//   - Returns the captured result, or an error code, to the host
//     (valid/ready handshake).
//   - A divide by zero is answered directly and the core is never started.
//   - A core that never completes is answered with a timeout after
//     TIMEOUT wait cycles.
//
// Parameters
//   TIMEOUT    maximum number of WAIT cycles before a timeout response (1..255)
//   GO_CYCLES  number of cycles go stays high per launch (1..3)
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous active-low reset
//   cmd_valid   host offers a command
//   cmd_ready   requester can take a command (IDLE only)
//   cmd_op      1 = multiply, 0 = divide
//   cmd_a       multiplier / divisor (two's complement)
//   cmd_b       multiplicand in [15:0] / dividend (two's complement)
//   input1      registered cmd_a to the core
//   input2      registered cmd_b to the core
//   selecc_op   registered cmd_op to the core
//   go          start request to the core
//   done        core completion level, cleared by the core on start
//   result      core result, valid while done is high
//   rsp_valid   response available to the host (RESP only)
//   rsp_ready   host takes the response
//   rsp_result  captured result, 0 on any error
//   rsp_err     00 ok, 01 divide-by-zero, 10 timeout
//   busy        high in every state except IDLE
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready for a command; operands latched on acceptance
// LAUNCH | go held high for GO_CYCLES cycles
// WAIT   | watching for a done rising edge, timeout counter running
// RESP   | response held on rsp_* until the host takes it

module muldiv_requester #(
   parameter int TIMEOUT   = 255,
   parameter int GO_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_op,
   input  logic [15:0] cmd_a,
   input  logic [31:0] cmd_b,
   output logic [15:0] input1,
   output logic [31:0] input2,
   output logic        selecc_op,
   output logic        go,
   input  logic        done,
   input  logic [31:0] result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic [1:0]  rsp_err,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_DIV0 = 2'b01;
   localparam logic [1:0] ERR_TMO  = 2'b10;

   // Last go_cnt value in LAUNCH, and last wait_cnt value before a timeout.
   localparam logic [1:0] GO_LAST   = 2'(GO_CYCLES - 1);
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [1:0]  go_cnt_q, go_cnt_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        done_q;
   logic [15:0] input1_d;
   logic [31:0] input2_d;
   logic        selecc_op_d;
   logic [31:0] rsp_result_d;
   logic [1:0]  rsp_err_d;

   logic        div_zero;
   logic        done_rise;

   assign div_zero  = ~cmd_op & (cmd_a == 16'd0);
   // done_q samples every cycle, so a level still high from the previous
   // operation never looks like a new edge when WAIT is entered.
   assign done_rise = done & ~done_q;

   assign busy      = (state_q != ST_IDLE);
   assign cmd_ready = (state_q == ST_IDLE) & reset;

   always_comb begin
      state_d      = state_q;
      go_cnt_d     = go_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      input1_d     = input1;
      input2_d     = input2;
      selecc_op_d  = selecc_op;
      rsp_result_d = rsp_result;
      rsp_err_d    = rsp_err;
      go           = 1'b0;
      rsp_valid    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               input1_d     = cmd_a;
               input2_d     = cmd_b;
               selecc_op_d  = cmd_op;
               rsp_result_d = 32'd0;
               go_cnt_d     = 2'd0;
               if (div_zero) begin
                  rsp_err_d = ERR_DIV0;
                  state_d   = ST_RESP;
               end else begin
                  rsp_err_d = ERR_OK;
                  state_d   = ST_LAUNCH;
               end
            end
         end

         ST_LAUNCH: begin
            go = 1'b1;
            if (go_cnt_q == GO_LAST) begin
               wait_cnt_d = 8'd0;
               state_d    = ST_WAIT;
            end else begin
               go_cnt_d = go_cnt_q + 2'd1;
            end
         end

         ST_WAIT: begin
            wait_cnt_d = wait_cnt_q + 8'd1;
            // Completion is tested first so it wins over a simultaneous timeout.
            if (done_rise) begin
               rsp_result_d = result;
               rsp_err_d    = ERR_OK;
               state_d      = ST_RESP;
            end else if (wait_cnt_q == WAIT_LAST) begin
               rsp_result_d = 32'd0;
               rsp_err_d    = ERR_TMO;
               state_d      = ST_RESP;
            end
         end

         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         go_cnt_q   <= 2'd0;
         wait_cnt_q <= 8'd0;
         done_q     <= 1'b0;
         input1     <= 16'd0;
         input2     <= 32'd0;
         selecc_op  <= 1'b0;
         rsp_result <= 32'd0;
         rsp_err    <= ERR_OK;
      end else begin
         state_q    <= state_d;
         go_cnt_q   <= go_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         done_q     <= done;
         input1     <= input1_d;
         input2     <= input2_d;
         selecc_op  <= selecc_op_d;
         rsp_result <= rsp_result_d;
         rsp_err    <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_muldiv_requester.sv
// Bench for muldiv_requester.
// Two instances are used:
//   - inst 0: TIMEOUT=255, for long core latencies.
//   - inst 1: TIMEOUT=10, for the timeout boundary.
// Each transaction is described by a command and a core done waveform.
// Expected response timing and content follow from the rules below.
module tb_muldiv_requester;

   localparam int GO = 2;
   localparam int TMO0 = 255;
   localparam int TMO1 = 10;

   logic        clk;
   logic [1:0]  reset;
   logic [1:0]  cmd_valid;
   logic [1:0]  cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_a [2];
   logic [31:0] cmd_b [2];
   logic [15:0] input1 [2];
   logic [31:0] input2 [2];
   logic [1:0]  selecc_op;
   logic [1:0]  go;
   logic [1:0]  done;
   logic [31:0] result [2];
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_result [2];
   logic [1:0]  rsp_err [2];
   logic [1:0]  busy;

   int checks = 0;
   int errors = 0;

   muldiv_requester #(.TIMEOUT(TMO0), .GO_CYCLES(GO)) dut0 (
      .clk(clk), .reset(reset[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_op(cmd_op[0]), .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .input1(input1[0]),
      .input2(input2[0]), .selecc_op(selecc_op[0]), .go(go[0]), .done(done[0]),
      .result(result[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_result(rsp_result[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
   );

   muldiv_requester #(.TIMEOUT(TMO1), .GO_CYCLES(GO)) dut1 (
      .clk(clk), .reset(reset[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_op(cmd_op[1]), .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .input1(input1[1]),
      .input2(input2[1]), .selecc_op(selecc_op[1]), .go(go[1]), .done(done[1]),
      .result(result[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_result(rsp_result[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          d;
      logic        op;
      logic [15:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        stale;
      int          drop_c;
      int          rise_c;
      int          bp;
      int          exp_lat;
      logic [1:0]  exp_err;
      logic [31:0] exp_res;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Core done level in cycle c of a transaction (cycle 0 = command accepted):
   // the previous level (stale) until drop_c, then high from rise_c on.
   function automatic logic wave(input logic stale, input int drop_c, input int rise_c, input int c);
      if (c < drop_c) return stale;
      return (rise_c != 0) && (c >= rise_c);
   endfunction

   // Reference model:
   //   - A divide by zero answers in cycle 1.
   //   - Otherwise the first done rising edge inside the wait window
   //     (cycles GO+1 .. GO+tmo) completes the transaction.
   //   - With no such edge, a timeout is answered after tmo wait cycles.
   task automatic model(input logic op, input logic [15:0] a, input logic [31:0] res,
                        input logic stale, input int drop_c, input int rise_c, input int tmo,
                        output int resp_c, output logic [1:0] err, output logic [31:0] r);
      bit found;
      found  = 0;
      resp_c = GO + tmo + 1;
      err    = 2'b10;
      r      = 32'd0;
      if (!op && a == 16'd0) begin
         resp_c = 1;
         err    = 2'b01;
      end else begin
         for (int c = GO + 1; c <= GO + tmo; c++) begin
            if (!found && wave(stale, drop_c, rise_c, c) && !wave(stale, drop_c, rise_c, c - 1)) begin
               found  = 1;
               resp_c = c + 1;
               err    = 2'b00;
               r      = res;
            end
         end
      end
   endtask

   // Runs one transaction starting at posedge+1, ending at posedge+1 after
   // the response handshake. Junk commands are offered while busy.
   task automatic run_txn(input int d, input logic op, input logic [15:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic stale, input int drop_c, input int rise_c,
                          input int bp, input int resp_c, input logic [1:0] exp_err,
                          input logic [31:0] exp_res, input string name);
      bit dz;
      dz = (!op && a == 16'd0);
      for (int c = 0; c <= resp_c + bp; c++) begin
         if (c == 0) begin
            cmd_valid[d] = 1'b1;
            cmd_op[d]    = op;
            cmd_a[d]     = a;
            cmd_b[d]     = b;
         end else begin
            cmd_valid[d] = 1'($urandom);
            cmd_op[d]    = 1'($urandom);
            cmd_a[d]     = 16'($urandom);
            cmd_b[d]     = $urandom;
         end
         done[d]      = wave(stale, drop_c, rise_c, c);
         result[d]    = done[d] ? res : ~res;
         rsp_ready[d] = (c < resp_c) ? 1'($urandom) : (c >= resp_c + bp);
         @(negedge clk);
         chk($sformatf("%s c%0d go", name, c), 32'(go[d]), 32'(!dz && c >= 1 && c <= GO));
         chk($sformatf("%s c%0d rsp_valid", name, c), 32'(rsp_valid[d]), 32'(c >= resp_c));
         chk($sformatf("%s c%0d busy", name, c), 32'(busy[d]), 32'(c >= 1));
         chk($sformatf("%s c%0d cmd_ready", name, c), 32'(cmd_ready[d]), 32'(c == 0));
         if (c >= 1) begin
            chk($sformatf("%s c%0d input1", name, c), 32'(input1[d]), 32'(a));
            chk($sformatf("%s c%0d input2", name, c), input2[d], b);
            chk($sformatf("%s c%0d selecc_op", name, c), 32'(selecc_op[d]), 32'(op));
         end
         if (c >= resp_c) begin
            chk($sformatf("%s c%0d rsp_result", name, c), rsp_result[d], exp_res);
            chk($sformatf("%s c%0d rsp_err", name, c), 32'(rsp_err[d]), 32'(exp_err));
         end
         @(posedge clk); #1;
      end
      cmd_valid[d] = 1'b0;
      rsp_ready[d] = 1'b0;
   endtask

   // Starts a multiply on inst 0 and pulls reset mid-cycle at abort_c
   // (no clock edge in between).
   task automatic reset_abort(input int abort_c, input string name);
      for (int c = 0; c < abort_c; c++) begin
         cmd_valid[0] = (c == 0);
         cmd_op[0]    = 1'b1;
         cmd_a[0]     = 16'h0009;
         cmd_b[0]     = 32'h0000_0004;
         done[0]      = 1'b0;
         result[0]    = 32'd36;
         rsp_ready[0] = 1'b0;
         @(posedge clk); #1;
      end
      cmd_valid[0] = 1'b0;
      #1;
      chk($sformatf("%s busy before", name), 32'(busy[0]), 32'd1);
      chk($sformatf("%s go before", name), 32'(go[0]), 32'(abort_c >= 1 && abort_c <= GO));
      #1 reset[0] = 1'b0;
      #1;
      chk($sformatf("%s go", name), 32'(go[0]), 32'd0);
      chk($sformatf("%s busy", name), 32'(busy[0]), 32'd0);
      chk($sformatf("%s rsp_valid", name), 32'(rsp_valid[0]), 32'd0);
      chk($sformatf("%s input1", name), 32'(input1[0]), 32'd0);
      chk($sformatf("%s rsp_result", name), rsp_result[0], 32'd0);
      @(negedge clk);
      reset[0] = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) begin
         done[0]      = (k >= 2);
         rsp_ready[0] = 1'b1;
         @(negedge clk);
         chk($sformatf("%s post k%0d rsp_valid", name, k), 32'(rsp_valid[0]), 32'd0);
         chk($sformatf("%s post k%0d busy", name, k), 32'(busy[0]), 32'd0);
         chk($sformatf("%s post k%0d cmd_ready", name, k), 32'(cmd_ready[0]), 32'd1);
         @(posedge clk); #1;
      end
      rsp_ready[0] = 1'b0;
   endtask

   initial begin
      int          rc;
      logic [1:0]  e;
      logic [31:0] r;

      //          d  op    a         b             res           stale drop rise bp lat err    res
      vecs[0] = '{0, 1'b1, 16'h0003, 32'h0000_0005, 32'd15,       1'b0, 0, 21, 0, 22, 2'b00, 32'd15};
      vecs[1] = '{0, 1'b0, 16'h0000, 32'd100,       32'h5555_AAAA, 1'b0, 0,  0, 0,  1, 2'b01, 32'd0};
      vecs[2] = '{0, 1'b0, 16'hFFF2, 32'd100,       32'hFFFF_FFF9, 1'b1, 4,  8, 0,  9, 2'b00, 32'hFFFF_FFF9};
      vecs[3] = '{1, 1'b1, 16'h0011, 32'h0000_0022, 32'h0000_0242, 1'b0, 0,  0, 0, 13, 2'b10, 32'd0};
      vecs[4] = '{1, 1'b1, 16'h0021, 32'h0000_0002, 32'hCAFE_0001, 1'b0, 0, 12, 0, 13, 2'b00, 32'hCAFE_0001};
      vecs[5] = '{1, 1'b1, 16'h0021, 32'h0000_0002, 32'hCAFE_0002, 1'b0, 0, 13, 0, 13, 2'b10, 32'd0};
      vecs[6] = '{0, 1'b1, 16'h0007, 32'h0000_0006, 32'd42,       1'b0, 0,  5, 5,  6, 2'b00, 32'd42};
      vecs[7] = '{1, 1'b1, 16'h0005, 32'h0000_0005, 32'd25,       1'b0, 0,  1, 0, 13, 2'b10, 32'd0};
      vecs[8] = '{0, 1'b1, 16'h0000, 32'd77,        32'd0,        1'b0, 0,  6, 2,  7, 2'b00, 32'd0};

      reset     = 2'b00;
      cmd_valid = 2'b00;
      cmd_op    = 2'b00;
      done      = 2'b00;
      rsp_ready = 2'b00;
      for (int i = 0; i < 2; i++) begin
         cmd_a[i]  = 16'd0;
         cmd_b[i]  = 32'd0;
         result[i] = 32'd0;
      end

      #3;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("reset%0d go", i), 32'(go[i]), 32'd0);
         chk($sformatf("reset%0d rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
         chk($sformatf("reset%0d busy", i), 32'(busy[i]), 32'd0);
         chk($sformatf("reset%0d rsp_result", i), rsp_result[i], 32'd0);
         chk($sformatf("reset%0d rsp_err", i), 32'(rsp_err[i]), 32'd0);
         chk($sformatf("reset%0d input1", i), 32'(input1[i]), 32'd0);
         chk($sformatf("reset%0d input2", i), input2[i], 32'd0);
         chk($sformatf("reset%0d selecc_op", i), 32'(selecc_op[i]), 32'd0);
      end
      @(negedge clk);
      reset = 2'b11;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) begin
         run_txn(vecs[i].d, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].stale,
                 vecs[i].drop_c, vecs[i].rise_c, vecs[i].bp, vecs[i].exp_lat,
                 vecs[i].exp_err, vecs[i].exp_res, $sformatf("vec%0d", i));
      end

      reset_abort(5, "rst_wait");
      reset_abort(1, "rst_launch");

      for (int n = 0; n < 40; n++) begin
         int          d, drop_c, rise_c, bp;
         logic        op, stale;
         logic [15:0] a;
         logic [31:0] b, res;
         d      = $urandom_range(0, 1);
         op     = 1'($urandom);
         a      = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
         b      = $urandom;
         res    = $urandom;
         stale  = 1'($urandom);
         drop_c = $urandom_range(0, 6);
         rise_c = $urandom_range(0, 16);
         bp     = $urandom_range(0, 3);
         model(op, a, res, stale, drop_c, rise_c, (d == 0) ? TMO0 : TMO1, rc, e, r);
         run_txn(d, op, a, b, res, stale, drop_c, rise_c, bp, rc, e, r, $sformatf("rnd%0d", n));
      end

      @(negedge clk);
      chk("final cmd_ready0", 32'(cmd_ready[0]), 32'd1);
      chk("final cmd_ready1", 32'(cmd_ready[1]), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
